qbus_dl11: RTL and testbench
============================

QBUS_DL11 -- requirements
Module: qbus_dl11

Interface
REQ-001 SHALL have parameter BASE, default 16'o177560: address of RCSR; RBUF=BASE+2, XCSR=BASE+4, XBUF=BASE+6.
REQ-002 SHALL have parameter VEC_RX, default 16'o000060: receiver interrupt vector.
REQ-003 SHALL have parameter VEC_TX, default 16'o000064: transmitter interrupt vector.
REQ-004 SHALL have parameter RPLY_DLY, default 2: clocks from strobe seen to rply_n asserted, range 0..15.
REQ-005 Ports (one clock; reset asynchronous, active-high):
- clk       in   1   bus clock, rising edge; all bus inputs are synchronous to it.
- rst       in   1   asynchronous active-high reset.
- ad_n      in   16  inverted AD bus as seen on pins.
- ad_out_n  out  16  inverted data driven onto AD.
- ad_oe     out  1   AD output enable.
- sync_n    in   1   address strobe.
- din_n     in   1   read strobe.
- dout_n    in   1   write strobe.
- wtbt_n    in   1   write/byte status.
- iako_n    in   1   interrupt acknowledge.
- rply_n    out  1   reply.
- virq_n    out  1   vectored interrupt request.
- tx_data   out  8   transmit byte.
- tx_stb    out  1   transmit byte valid.
- tx_ack    in   1   transmit byte consumed.
- rx_data   in   8   receive byte.
- rx_stb    in   1   receive byte valid, single-clock pulse.

Function
REQ-006 SHALL latch ~ad_n into addr and ~wtbt_n into wflg on the clock where sync_n is first seen low; sel asserts iff addr[15:3]==BASE[15:3].
REQ-007 SHALL implement FSM IDLE, ADDR, RD, WR, DONE, IAK; IDLE->ADDR on sync_n falling.
REQ-008 ADDR->RD on din_n low with sel; ADDR->WR on dout_n low with sel; unselected cycles stay in ADDR with rply_n high until sync_n rises, then IDLE.
REQ-009 RD: ad_oe=1 and ad_out_n=~register data from the first RD clock; rply_n low RPLY_DLY clocks later; -> DONE.
REQ-010 WR: register updated on the clock dout_n is first seen low; rply_n low RPLY_DLY clocks later; -> DONE.
REQ-011 DONE: on din_n and dout_n both high, next clock ad_oe=0, rply_n=1; return to ADDR if sync_n low, else IDLE.
REQ-012 sync_n rising in any state SHALL force IDLE, ad_oe=0, rply_n=1 next clock.
REQ-013 RCSR read = {8'b0, rx_done, rx_ie, 6'b0}; RBUF read = {8'b0, rx_buf} and clears rx_done.
REQ-014 XCSR read = {8'b0, tx_rdy, tx_ie, 6'b0}; XBUF read = 16'o000000.
REQ-015 Write to RCSR/XCSR updates bit 6 (IE) only; byte write (wflg) with addr[0]=1 SHALL be ignored.
REQ-016 Write to XBUF (word or low byte) with tx_rdy=1: tx_data=data[7:0], tx_stb=1, tx_rdy=0; with tx_rdy=0 the write is dropped but replied.
REQ-017 tx_stb holds until the clock tx_ack is seen high; then tx_stb=0, tx_rdy=1 next clock.
REQ-018 rx_stb SHALL load rx_buf and set rx_done; overrun overwrites rx_buf; rx_stb coincident with RBUF read keeps rx_done=1.
REQ-019 rx_req = rx_done & rx_ie & ~rx_ackd; tx_req = tx_rdy & tx_ie & ~tx_ackd; virq_n = ~(rx_req|tx_req), registered.
REQ-020 IDLE/ADDR with iako_n low, din_n low, virq_n low -> IAK: drive VEC_RX if rx_req else VEC_TX (rx wins), set matching *_ackd, rply_n low after RPLY_DLY, then DONE.
REQ-021 iako_n low with no pending request SHALL not reply (upstream daisy-chain times out).
REQ-022 rx_ackd clears when rx_done falls or RCSR written; tx_ackd clears when tx_rdy falls or XCSR written.
REQ-023 Only one of RD/WR/IAK SHALL be active per strobe; ad_oe=1 only in RD/IAK/following DONE.

Reset
REQ-024 While rst=1: FSM=IDLE, ad_oe=0, ad_out_n=16'hFFFF, rply_n=1, virq_n=1, tx_stb=0, tx_data=0, tx_rdy=1, tx_ie=0, rx_done=0, rx_ie=0, rx_buf=0, *_ackd=0.
REQ-025 rst asserted mid-cycle SHALL release AD and rply_n immediately (asynchronously) and abort any pending tx_stb.

Verification
REQ-026 Read XCSR after reset, RPLY_DLY=2 -> ~ad_out_n=16'o000200, rply_n low 2 clocks after din_n low, released 1 clock after din_n high.
REQ-027 Word write 16'o000101 to XBUF -> tx_stb=1, tx_data=8'o101, XCSR reads 16'o000000; tx_ack -> XCSR reads 16'o000200.
REQ-028 Write XCSR=16'o000100 while tx_rdy -> virq_n low; IAKO+DIN -> vector 16'o000064, virq_n high; XBUF write then tx_ack -> virq_n low again.
REQ-029 rx_ie=1 and tx_ie=1, rx_stb with 8'h41 -> IAK returns 16'o000060 first, then 16'o000064; RBUF read returns 16'o000101 and clears rx_done.
REQ-030 Access 16'o177570 (unselected) -> rply_n stays 1, ad_oe stays 0 until sync_n rises.
REQ-031 rst pulse during RD with rply_n low -> rply_n=1, ad_oe=0 same cycle; XCSR reads 16'o000200 afterwards.

Source files
------------

// File: rtl/qbus_dl11.sv
// DL11-style console serial interface as a Qbus slave: four registers (RCSR/RBUF/XCSR/XBUF),
// programmed-delay reply, and vectored interrupts for the receiver and transmitter.
module qbus_dl11 #(
  parameter logic [15:0] BASE     = 16'o177560,
  parameter logic [15:0] VEC_RX   = 16'o000060,
  parameter logic [15:0] VEC_TX   = 16'o000064,
  parameter int unsigned RPLY_DLY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ad_n,
  output logic [15:0] ad_out_n,
  output logic        ad_oe,
  input  logic        sync_n,
  input  logic        din_n,
  input  logic        dout_n,
  input  logic        wtbt_n,
  input  logic        iako_n,
  output logic        rply_n,
  output logic        virq_n,
  output logic [7:0]  tx_data,
  output logic        tx_stb,
  input  logic        tx_ack,
  input  logic [7:0]  rx_data,
  input  logic        rx_stb
);

  localparam bit         DlyZero = (RPLY_DLY == 0);
  localparam logic [3:0] DlyCnt  = 4'(RPLY_DLY);

  typedef enum logic [2:0] {StIdle, StAddr, StRd, StWr, StDone, StIak} state_e;

  state_e      state;
  logic [15:0] addr;
  logic        wflg;
  logic [3:0]  cnt;
  logic        sync_prev;

  logic        rx_done, rx_ie, rx_ackd;
  logic [7:0]  rx_buf;
  logic        tx_rdy, tx_ie, tx_ackd;

  logic        sel, sync_rise, rd_go, wr_go, wr_ok, iak_go;
  logic        wr_rcsr, wr_xcsr, tx_go, rd_rbuf;
  logic        rx_req, tx_req, rx_done_nx, tx_rdy_nx;
  logic [1:0]  idx;
  logic [15:0] rdata, iak_vec;

  always_comb begin
    sel       = (addr[15:3] == BASE[15:3]);
    idx       = addr[2:1];
    sync_rise = sync_n & ~sync_prev;
    rd_go     = (state == StAddr) & ~sync_n & ~din_n & sel;
    wr_go     = (state == StAddr) & ~sync_n & din_n & ~dout_n & sel;
    // Odd-address byte writes hit only the unimplemented high bytes.
    wr_ok     = wr_go & ~(wflg & addr[0]);
    iak_go    = ((state == StIdle) | ((state == StAddr) & ~sel)) & ~sync_rise &
                ~iako_n & ~din_n & ~virq_n;
    wr_rcsr   = wr_ok & (idx == 2'd0);
    wr_xcsr   = wr_ok & (idx == 2'd2);
    tx_go     = wr_ok & (idx == 2'd3) & tx_rdy;
    rd_rbuf   = rd_go & (idx == 2'd1);
    rx_req    = rx_done & rx_ie & ~rx_ackd;
    tx_req    = tx_rdy & tx_ie & ~tx_ackd;
    iak_vec   = rx_req ? VEC_RX : VEC_TX;
    rx_done_nx = rx_stb ? 1'b1 : (rd_rbuf ? 1'b0 : rx_done);
    tx_rdy_nx  = tx_go ? 1'b0 : ((tx_stb & tx_ack) ? 1'b1 : tx_rdy);
    rdata = 16'h0000;
    case (idx)
      2'd0:    rdata = {8'h00, rx_done, rx_ie, 6'b0};
      2'd1:    rdata = {8'h00, rx_buf};
      2'd2:    rdata = {8'h00, tx_rdy, tx_ie, 6'b0};
      default: rdata = 16'h0000;
    endcase
  end

  // Bus protocol FSM; all bus outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      addr      <= 16'h0000;
      wflg      <= 1'b0;
      cnt       <= 4'd0;
      sync_prev <= 1'b1;
      ad_oe     <= 1'b0;
      ad_out_n  <= 16'hFFFF;
      rply_n    <= 1'b1;
    end else begin
      sync_prev <= sync_n;
      if (sync_rise) begin
        state    <= StIdle;
        ad_oe    <= 1'b0;
        ad_out_n <= 16'hFFFF;
        rply_n   <= 1'b1;
      end else begin
        case (state)
          StIdle, StAddr: begin
            if (rd_go) begin
              state    <= DlyZero ? StDone : StRd;
              ad_oe    <= 1'b1;
              ad_out_n <= ~rdata;
              rply_n   <= !DlyZero;
              cnt      <= 4'd1;
            end else if (wr_go) begin
              state  <= DlyZero ? StDone : StWr;
              rply_n <= !DlyZero;
              cnt    <= 4'd1;
            end else if (iak_go) begin
              state    <= DlyZero ? StDone : StIak;
              ad_oe    <= 1'b1;
              ad_out_n <= ~iak_vec;
              rply_n   <= !DlyZero;
              cnt      <= 4'd1;
            end else if (state == StIdle && !sync_n) begin
              state <= StAddr;
              addr  <= ~ad_n;
              wflg  <= ~wtbt_n;
            end else if (state == StAddr && sync_n) begin
              state <= StIdle;
            end
          end
          StRd, StWr, StIak: begin
            if (cnt == DlyCnt) begin
              rply_n <= 1'b0;
              state  <= StDone;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          StDone: begin
            if (din_n && dout_n) begin
              ad_oe    <= 1'b0;
              ad_out_n <= 16'hFFFF;
              rply_n   <= 1'b1;
              state    <= sync_n ? StIdle : StAddr;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  // Device registers, transmit handshake and interrupt request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_done <= 1'b0;
      rx_ie   <= 1'b0;
      rx_buf  <= 8'h00;
      rx_ackd <= 1'b0;
      tx_rdy  <= 1'b1;
      tx_ie   <= 1'b0;
      tx_ackd <= 1'b0;
      tx_stb  <= 1'b0;
      tx_data <= 8'h00;
      virq_n  <= 1'b1;
    end else begin
      rx_done <= rx_done_nx;
      tx_rdy  <= tx_rdy_nx;
      if (rx_stb) rx_buf <= rx_data;
      if (wr_rcsr) rx_ie <= ~ad_n[6];
      if (wr_xcsr) tx_ie <= ~ad_n[6];
      if (tx_go) begin
        tx_data <= ~ad_n[7:0];
        tx_stb  <= 1'b1;
      end else if (tx_stb && tx_ack) begin
        tx_stb <= 1'b0;
      end
      if (iak_go && rx_req) rx_ackd <= 1'b1;
      else if (wr_rcsr || (rx_done && !rx_done_nx)) rx_ackd <= 1'b0;
      if (iak_go && !rx_req && tx_req) tx_ackd <= 1'b1;
      else if (wr_xcsr || (tx_rdy && !tx_rdy_nx)) tx_ackd <= 1'b0;
      virq_n <= ~(rx_req | tx_req);
    end
  end

endmodule

// File: tb/tb_qbus_dl11.sv
// Directed self-checking bench for qbus_dl11 with default parameters (RPLY_DLY=2).
module tb_qbus_dl11;

  logic        clk, rst;
  logic [15:0] ad_n, ad_out_n;
  logic        ad_oe, sync_n, din_n, dout_n, wtbt_n, iako_n, rply_n, virq_n;
  logic [7:0]  tx_data, rx_data;
  logic        tx_stb, tx_ack, rx_stb;

  int total = 0;
  int bad   = 0;

  localparam logic [15:0] RCSR = 16'o177560;
  localparam logic [15:0] RBUF = 16'o177562;
  localparam logic [15:0] XCSR = 16'o177564;
  localparam logic [15:0] XBUF = 16'o177566;

  qbus_dl11 dut (
    .clk      (clk),
    .rst      (rst),
    .ad_n     (ad_n),
    .ad_out_n (ad_out_n),
    .ad_oe    (ad_oe),
    .sync_n   (sync_n),
    .din_n    (din_n),
    .dout_n   (dout_n),
    .wtbt_n   (wtbt_n),
    .iako_n   (iako_n),
    .rply_n   (rply_n),
    .virq_n   (virq_n),
    .tx_data  (tx_data),
    .tx_stb   (tx_stb),
    .tx_ack   (tx_ack),
    .rx_data  (rx_data),
    .rx_stb   (rx_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Full read cycle; checks data, reply timing and release.
  task automatic bus_read(input logic [15:0] a, input logic [15:0] exp, input string tag);
    ad_n = ~a; wtbt_n = 1'b1; sync_n = 1'b0; tick;
    ad_n = 16'hFFFF; din_n = 1'b0; tick;
    chk({tag, ".data"}, {15'b0, ad_oe, ~ad_out_n}, {15'b0, 1'b1, exp});
    tick;
    chk({tag, ".rply_early"}, {31'b0, rply_n}, 32'd1);
    tick;
    chk({tag, ".rply"}, {31'b0, rply_n}, 32'd0);
    din_n = 1'b1; tick;
    chk({tag, ".release"}, {30'b0, ad_oe, rply_n}, 32'd1);
    sync_n = 1'b1; tick;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic byte_w,
                           input string tag);
    ad_n = ~a; wtbt_n = ~byte_w; sync_n = 1'b0; tick;
    ad_n = ~d; wtbt_n = 1'b1; dout_n = 1'b0; tick;
    tick; tick;
    chk({tag, ".rply"}, {31'b0, rply_n}, 32'd0);
    dout_n = 1'b1; ad_n = 16'hFFFF; tick;
    chk({tag, ".release"}, {30'b0, ad_oe, rply_n}, 32'd1);
    sync_n = 1'b1; tick;
  endtask

  task automatic iak(input logic [15:0] vec, input string tag);
    din_n = 1'b0; iako_n = 1'b0; tick;
    chk({tag, ".vec"}, {15'b0, ad_oe, ~ad_out_n}, {15'b0, 1'b1, vec});
    tick; tick;
    chk({tag, ".rply"}, {31'b0, rply_n}, 32'd0);
    din_n = 1'b1; iako_n = 1'b1; tick;
    chk({tag, ".release"}, {30'b0, ad_oe, rply_n}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; ad_n = 16'hFFFF; sync_n = 1'b1; din_n = 1'b1; dout_n = 1'b1;
    wtbt_n = 1'b1; iako_n = 1'b1; tx_ack = 1'b0; rx_data = 8'h00; rx_stb = 1'b0;
    tick;
    chk("reset.ad", {15'b0, ad_oe, ad_out_n}, {16'h0000, 16'hFFFF});
    chk("reset.ctl", {28'b0, rply_n, virq_n, tx_stb, 1'b0}, {28'b0, 4'b1100});
    chk("reset.tx_data", {24'b0, tx_data}, 32'd0);
    rst = 1'b0; tick;

    bus_read(XCSR, 16'o000200, "xcsr_reset");
    bus_read(RCSR, 16'o000000, "rcsr_reset");
    bus_read(RBUF, 16'o000000, "rbuf_reset");

    // Transmit path and dropped write while busy.
    bus_write(XBUF, 16'o000101, 1'b0, "xbuf_wr");
    chk("tx_out", {23'b0, tx_stb, tx_data}, {23'b0, 1'b1, 8'o101});
    bus_read(XCSR, 16'o000000, "xcsr_busy");
    bus_write(XBUF, 16'o000102, 1'b0, "xbuf_drop");
    chk("tx_drop", {23'b0, tx_stb, tx_data}, {23'b0, 1'b1, 8'o101});
    tx_ack = 1'b1; tick; tx_ack = 1'b0;
    chk("tx_ack", {31'b0, tx_stb}, 32'd0);
    bus_read(XCSR, 16'o000200, "xcsr_done");

    // Odd-address byte write must be ignored.
    bus_write(XCSR + 16'd1, 16'o000100, 1'b1, "xcsr_byte");
    bus_read(XCSR, 16'o000200, "xcsr_byte_ign");
    chk("virq_idle", {31'b0, virq_n}, 32'd1);

    // Transmitter interrupt.
    bus_write(XCSR, 16'o000100, 1'b0, "xcsr_ie");
    chk("virq_tx", {31'b0, virq_n}, 32'd0);
    iak(16'o000064, "iak_tx");
    chk("virq_acked", {31'b0, virq_n}, 32'd1);
    bus_write(XBUF, 16'o000103, 1'b0, "xbuf_wr2");
    chk("tx_out2", {23'b0, tx_stb, tx_data}, {23'b0, 1'b1, 8'o103});
    chk("virq_busy", {31'b0, virq_n}, 32'd1);
    tx_ack = 1'b1; tick; tx_ack = 1'b0; tick;
    chk("virq_tx_again", {31'b0, virq_n}, 32'd0);

    // Receiver interrupt takes priority.
    bus_write(RCSR, 16'o000100, 1'b0, "rcsr_ie");
    rx_data = 8'h41; rx_stb = 1'b1; tick; rx_stb = 1'b0; tick;
    iak(16'o000060, "iak_rx");
    tick;
    iak(16'o000064, "iak_tx2");
    tick;
    bus_read(RCSR, 16'o000300, "rcsr_done");
    bus_read(RBUF, 16'o000101, "rbuf");
    bus_read(RCSR, 16'o000100, "rcsr_clr");

    // Acknowledge with nothing pending gets no reply.
    chk("virq_none", {31'b0, virq_n}, 32'd1);
    din_n = 1'b0; iako_n = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    chk("iak_noreply", {30'b0, ad_oe, rply_n}, 32'd1);
    din_n = 1'b1; iako_n = 1'b1; tick;

    // Unselected address.
    ad_n = ~16'o177570; sync_n = 1'b0; tick;
    ad_n = 16'hFFFF; din_n = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    chk("unsel", {30'b0, ad_oe, rply_n}, 32'd1);
    din_n = 1'b1; sync_n = 1'b1; tick;
    bus_read(XCSR, 16'o000300, "xcsr_after_unsel");

    // Reset in the middle of a replied read, with a transmit byte pending.
    bus_write(XBUF, 16'o000105, 1'b0, "xbuf_wr3");
    chk("tx_pend", {31'b0, tx_stb}, 32'd1);
    ad_n = ~XCSR; sync_n = 1'b0; tick;
    ad_n = 16'hFFFF; din_n = 1'b0; tick; tick; tick;
    chk("rd_replied", {30'b0, ad_oe, rply_n}, 32'd2);
    rst = 1'b1; #1;
    chk("rst_async", {14'b0, ad_oe, rply_n, ad_out_n}, {14'b0, 2'b01, 16'hFFFF});
    chk("rst_tx_abort", {31'b0, tx_stb}, 32'd0);
    tick; rst = 1'b0; din_n = 1'b1; sync_n = 1'b1; tick;
    bus_read(XCSR, 16'o000200, "xcsr_post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
